mac_ctrl: RTL and testbench

MAC_CTRL -- requirements
Module: mac_ctrl

---
 rtl/mac_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mac_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_ctrl.sv
// mac_ctrl: sequencer for a windowed multiply-accumulate job.
// A job runs NUM_WIN windows. Each window issues TAPS operand reads, drains
// the one-cycle buffer latency, then stores the accumulator value.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   start, abort     job request (sampled in IDLE) / synchronous cancel
//   busy, done       job in progress / one-cycle end-of-job pulse
//   rd_en, a_addr,   operand buffer read strobe, kernel address,
//   b_addr           feature address
//   mac_en, mac_clr  accumulate enable / accumulator clear to the datapath
//   acc_in           accumulator value from the datapath
//   result,          captured window sum, its one-cycle qualifier,
//   result_valid,    and the index of the window it belongs to
//   win_idx
//   sat              (MAC_CTRL_SAT_EN only) result was clamped to 255
//
// Build option: define MAC_CTRL_SAT_EN to clamp stored sums above 255.
module mac_ctrl #(
    parameter int unsigned  TAPS    = 4,
    parameter int unsigned  NUM_WIN = 4,
    parameter int unsigned  ADDR_W  = 4,
    localparam int unsigned DATA_W  = 19,
    localparam int unsigned WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic [DATA_W-1:0] acc_in,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic [WIN_W-1:0]  win_idx
`ifdef MAC_CTRL_SAT_EN
    ,
    output logic              sat
`endif
);

    localparam int unsigned TAP_W = $clog2(TAPS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic               abort_hit;
    logic               store_ok;
    logic               issue_d;
    logic [ADDR_W-1:0]  b_addr_d;
    logic [DATA_W-1:0]  store_val;
`ifdef MAC_CTRL_SAT_EN
    logic               over;
`endif

    // State and counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tap_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            win_q   <= win_d;
        end
    end

    // Next-state, counters and next-cycle output decode
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        win_d     = win_q;
        abort_hit = 1'b0;
        store_ok  = 1'b0;
        issue_d   = 1'b0;
        b_addr_d  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    tap_d   = '0;
                    win_d   = '0;
                end
            end
            ISSUE: begin
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            DRAIN: state_d = STORE;
            STORE: begin
                if (win_q == WIN_W'(NUM_WIN - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                    tap_d   = '0;
                    win_d   = win_q + WIN_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Cancel takes priority over every transition, including STORE
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            tap_d     = '0;
            win_d     = '0;
            abort_hit = 1'b1;
        end

        store_ok = (state_q == STORE) && !abort;
        issue_d  = (state_d == ISSUE);
        b_addr_d = ADDR_W'(32'(win_d) * TAPS + 32'(tap_d));
    end

    // Value loaded into result at STORE
`ifdef MAC_CTRL_SAT_EN
    assign over      = (acc_in > DATA_W'(255));
    assign store_val = over ? DATA_W'(255) : acc_in;
`else
    assign store_val = acc_in;
`endif

    // Registered outputs; decoded from next state so they line up with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_en        <= 1'b0;
            a_addr       <= '0;
            b_addr       <= '0;
            mac_en       <= 1'b0;
            mac_clr      <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
            win_idx      <= '0;
`ifdef MAC_CTRL_SAT_EN
            sat          <= 1'b0;
`endif
        end else begin
            busy         <= (state_d != IDLE);
            done         <= (state_d == DONE);
            rd_en        <= issue_d;
            a_addr       <= issue_d ? ADDR_W'(tap_d) : '0;
            b_addr       <= issue_d ? b_addr_d : '0;
            // models the one-cycle operand buffer read latency
            mac_en       <= rd_en;
            mac_clr      <= (state_d == STORE) || abort_hit;
            result_valid <= store_ok;
            if (store_ok) begin
                result  <= store_val;
                win_idx <= win_q;
            end
`ifdef MAC_CTRL_SAT_EN
            sat          <= store_ok && over;
`endif
        end
    end

endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl: self-checking bench for mac_ctrl with a behavioural operand
// buffer and accumulator, a cycle-position reference model, directed tables
// and randomized start/abort traffic.
module tb_mac_ctrl;

    localparam int TAPS    = 4;
    localparam int NUM_WIN = 4;
    localparam int ADDR_W  = 4;
    localparam int WPER    = TAPS + 2;
    localparam int LAST    = NUM_WIN * WPER + 1;   // DONE cycle index of a job

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [3:0]  a_addr;
    logic [3:0]  b_addr;
    logic        mac_en;
    logic        mac_clr;
    logic [18:0] acc_in;
    logic [18:0] result;
    logic        result_valid;
    logic [1:0]  win_idx;
`ifdef MAC_CTRL_SAT_EN
    logic        sat;
`endif

    mac_ctrl #(.TAPS(TAPS), .NUM_WIN(NUM_WIN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .rd_en(rd_en),
        .a_addr(a_addr), .b_addr(b_addr),
        .mac_en(mac_en), .mac_clr(mac_clr), .acc_in(acc_in),
        .result(result), .result_valid(result_valid), .win_idx(win_idx)
`ifdef MAC_CTRL_SAT_EN
        , .sat(sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buffer (1-cycle read) and accumulator datapath
    logic [7:0]  a_mem [16];
    logic [7:0]  b_mem [16];
    logic [7:0]  a_d, b_d;
    logic [18:0] acc;
    always @(posedge clk) begin
        a_d <= a_mem[a_addr];
        b_d <= b_mem[b_addr];
        if (mac_clr)     acc <= '0;
        else if (mac_en) acc <= acc + 19'(a_d) * 19'(b_d);
    end
    assign acc_in = acc;

    // Reference model: n = cycle position within the current job (0 = idle)
    int          n;
    bit          prev_rd;
    bit          clr_flag;
    logic [18:0] exp_res;
    int          exp_widx;
    bit          exp_sat;

    int errors = 0;
    int checks = 0;
    int done_cnt, rv_cnt, rd_cnt, clr_cnt, idle_cnt, bidx, bseq_bad;

    function automatic int pos(int k);
        return (k - 1) % WPER;
    endfunction
    function automatic bit rd_of(int k);
        return (k >= 1) && (k < LAST) && (pos(k) < TAPS);
    endfunction
    function automatic bit rv_of(int k);
        return (k > WPER) && (k <= LAST) && (pos(k) == 0);
    endfunction
    function automatic int wsum(int w);
        int s = 0;
        for (int t = 0; t < TAPS; t++) s += int'(a_mem[t]) * int'(b_mem[w * TAPS + t]);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        bit rd;
        int p, w;
        rd = rd_of(n);
        p  = pos(n);
        w  = (n - 1) / WPER;
        chk("busy",         32'(busy),         32'(n != 0));
        chk("done",         32'(done),         32'(n == LAST));
        chk("rd_en",        32'(rd_en),        32'(rd));
        chk("a_addr",       32'(a_addr),       rd ? 32'(p) : 32'd0);
        chk("b_addr",       32'(b_addr),       rd ? 32'(w * TAPS + p) : 32'd0);
        chk("mac_en",       32'(mac_en),       32'(prev_rd));
        chk("mac_clr",      32'(mac_clr),      32'(clr_flag || (n != 0 && n < LAST && p == TAPS + 1)));
        chk("result_valid", 32'(result_valid), 32'(rv_of(n)));
        chk("result",       32'(result),       32'(exp_res));
        chk("win_idx",      32'(win_idx),      32'(exp_widx));
`ifdef MAC_CTRL_SAT_EN
        chk("sat",          32'(sat),          32'(rv_of(n) && exp_sat));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on negedge
    task automatic tick(input bit st, input bit ab);
        int nn, w, s;
        start = st;
        abort = ab;
        @(posedge clk);
        if (n != 0 && ab)   nn = 0;
        else if (n == 0)    nn = st ? 1 : 0;
        else if (n == LAST) nn = 0;
        else                nn = n + 1;
        prev_rd  = rd_of(n);
        clr_flag = (n != 0) && ab;
        if (rv_of(nn)) begin
            w = (nn - 1) / WPER - 1;
            s = wsum(w);
`ifdef MAC_CTRL_SAT_EN
            exp_sat = (s > 255);
            if (s > 255) s = 255;
`endif
            exp_res  = 19'(s);
            exp_widx = w;
        end
        n = nn;
        @(negedge clk);
        check_model();
        if (done)         done_cnt++;
        if (result_valid) rv_cnt++;
        if (mac_clr)      clr_cnt++;
        if (!busy)        idle_cnt++;
        if (rd_en) begin
            rd_cnt++;
            if (32'(b_addr) != bidx) bseq_bad++;
            bidx++;
        end
    endtask

    task automatic clear_stats();
        done_cnt = 0; rv_cnt = 0; rd_cnt = 0; clr_cnt = 0;
        idle_cnt = 0; bidx = 0; bseq_bad = 0;
    endtask

    // Assert reset asynchronously, check the forced values, hold, release
    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("rst_busy",    32'(busy),         32'd0);
        chk("rst_done",    32'(done),         32'd0);
        chk("rst_rd_en",   32'(rd_en),        32'd0);
        chk("rst_mac_en",  32'(mac_en),       32'd0);
        chk("rst_rv",      32'(result_valid), 32'd0);
        chk("rst_addr",    32'({a_addr, b_addr}), 32'd0);
        chk("rst_result",  32'(result),       32'd0);
        chk("rst_win_idx", 32'(win_idx),      32'd0);
        chk("rst_mac_clr", 32'(mac_clr),      32'd1);
        n = 0; prev_rd = 0; clr_flag = 0; exp_res = '0; exp_widx = 0; exp_sat = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_clr", 32'(mac_clr), 32'd1);
        rst = 1'b1;
    endtask

    task automatic load_ref();
        int av[4]  = '{1, 2, 3, 4};
        int bv[16] = '{1, 2, 4, 5, 2, 3, 5, 6, 4, 5, 7, 8, 5, 6, 8, 9};
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = (i < 4) ? 8'(av[i]) : 8'd0;
            b_mem[i] = 8'(bv[i]);
        end
    endtask

    typedef struct {
        bit st;
        int ncyc;
        bit busy;
        bit rv;
        int res;
        int widx;
        bit done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // {start, cycles to advance, busy, result_valid, result, win_idx, done}
        vecs[0] = '{1, 1, 1, 0,  0, 0, 0};   // cycle 1: job running
        vecs[1] = '{0, 6, 1, 1, 37, 0, 0};   // cycle 7: window 0
        vecs[2] = '{0, 1, 1, 0, 37, 0, 0};   // pulse is one cycle, result holds
        vecs[3] = '{0, 5, 1, 1, 47, 1, 0};   // cycle 13
        vecs[4] = '{0, 6, 1, 1, 67, 2, 0};   // cycle 19
        vecs[5] = '{0, 6, 1, 1, 77, 3, 1};   // cycle 25: last window + done
        vecs[6] = '{0, 1, 0, 0, 77, 3, 0};   // back in IDLE, busy low
        vecs[7] = '{0, 3, 0, 0, 77, 3, 0};   // idle, result still held

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        clear_stats();
        load_ref();
        #1;
        do_reset();

        // Reference job from the table
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].st, 1'b0);
            for (int k = 1; k < vecs[i].ncyc; k++) tick(1'b0, 1'b0);
            chk("vec_busy",    32'(busy),         32'(vecs[i].busy));
            chk("vec_rv",      32'(result_valid), 32'(vecs[i].rv));
            chk("vec_result",  32'(result),       32'(vecs[i].res));
            chk("vec_win_idx", 32'(win_idx),      32'(vecs[i].widx));
            chk("vec_done",    32'(done),         32'(vecs[i].done));
        end

        // Large operands: clamp with the option, full sum without
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = 8'd200;
            b_mem[i] = 8'd200;
        end
        clear_stats();
        tick(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);
`ifdef MAC_CTRL_SAT_EN
        chk("big_result", 32'(result), 32'd255);
        chk("big_sat",    32'(sat),    32'd1);
`else
        chk("big_result", 32'(result), 32'd160000);
`endif
        repeat (19) tick(1'b0, 1'b0);
        chk("job_rd_cycles", 32'(rd_cnt),   32'd16);
        chk("job_b_seq_bad", 32'(bseq_bad), 32'd0);
        chk("job_b_count",   32'(bidx),     32'd16);
        chk("job_clr_count", 32'(clr_cnt),  32'd4);
        chk("job_done_cnt",  32'(done_cnt), 32'd1);

        // start held high: jobs back to back through one IDLE cycle
        load_ref();
        clear_stats();
        repeat (60) tick(1'b1, 1'b0);
        chk("held_done_cnt", 32'(done_cnt), 32'd2);
        chk("held_idle_cnt", 32'(idle_cnt), 32'd2);
        repeat (30) tick(1'b0, 1'b0);

        // abort during window 2 ISSUE
        tick(1'b1, 1'b0);
        repeat (13) tick(1'b0, 1'b0);
        clear_stats();
        tick(1'b0, 1'b1);
        chk("abort_busy",  32'(busy),    32'd0);
        chk("abort_clr",   32'(mac_clr), 32'd1);
        chk("abort_rd_en", 32'(rd_en),   32'd0);
        repeat (30) tick(1'b0, 1'b0);
        chk("abort_rv_cnt",   32'(rv_cnt),   32'd0);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        tick(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);
        chk("restart_rv",     32'(result_valid), 32'd1);
        chk("restart_result", 32'(result),       32'd37);
        repeat (20) tick(1'b0, 1'b0);

        // reset pulsed in the middle of DRAIN
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        #2;
        do_reset();
        clear_stats();
        repeat (40) tick(1'b0, 1'b0);
        chk("post_rst_done", 32'(done_cnt), 32'd0);
        chk("post_rst_rv",   32'(rv_cnt),   32'd0);

        // Randomized start/abort traffic with fresh operands between jobs
        for (int it = 0; it < 1500; it++) begin
            if (n == 0 && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 16; i++) begin
                    a_mem[i] = 8'($urandom_range(0, 255));
                    b_mem[i] = 8'($urandom_range(0, 255));
                end
            end
            tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 79) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
